// File: rtl/poly1305_pkg.sv
// Shared definitions for the Poly1305 block framer: FSM state encoding,
// block/word geometry, input segment type codes and byte-lane helpers.
package poly1305_pkg;

  localparam int BLK_BYTES  = 16;
  localparam int WORD_BYTES = 4;

  localparam logic TYPE_AAD = 1'b0;
  localparam logic TYPE_PLD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    AAD_FILL,
    AAD_OUT,
    PLD_FILL,
    PLD_OUT,
    LEN_OUT,
    DONE
  } state_t;

  // Number of valid bytes in a word keep mask.
  function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
    return {2'b00, keep[0]} + {2'b00, keep[1]} + {2'b00, keep[2]} + {2'b00, keep[3]};
  endfunction

  // True when the keep mask is a run of ones starting at lane 0 (or empty).
  function automatic logic keep_contig(input logic [3:0] keep);
    return (keep == 4'h0) || (keep == 4'h1) || (keep == 4'h3) ||
           (keep == 4'h7) || (keep == 4'hF);
  endfunction

endpackage

// File: rtl/poly1305_block_framer_if.sv
// Stream bundle of the framer: 32-bit input words plus the AAD, payload and
// length-block outputs. slave = framer side, master = producer/consumer side.
interface poly1305_block_framer_if;
  logic         in_valid;
  logic [31:0]  in_data;
  logic [3:0]   in_keep;
  logic         in_type;
  logic         in_last;
  logic         in_ready;

  logic         aad_valid;
  logic [127:0] aad_data;
  logic [15:0]  aad_keep;
  logic         aad_ready;

  logic         pld_valid;
  logic [127:0] pld_data;
  logic [15:0]  pld_keep;
  logic         pld_ready;

  logic         len_valid;
  logic [127:0] len_block;
  logic         len_ready;

  modport slave (
    input  in_valid, in_data, in_keep, in_type, in_last,
    output in_ready,
    output aad_valid, aad_data, aad_keep,
    input  aad_ready,
    output pld_valid, pld_data, pld_keep,
    input  pld_ready,
    output len_valid, len_block,
    input  len_ready
  );

  modport master (
    output in_valid, in_data, in_keep, in_type, in_last,
    input  in_ready,
    input  aad_valid, aad_data, aad_keep,
    output aad_ready,
    input  pld_valid, pld_data, pld_keep,
    output pld_ready,
    input  len_valid, len_block,
    output len_ready
  );
endinterface

// File: rtl/poly1305_byte_packer.sv
// 32-to-128 bit accumulator: writes kept bytes of each word at the current
// fill offset, keeps unwritten bytes at zero and tracks per-byte keep bits.
module poly1305_byte_packer
  import poly1305_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [31:0]  wr_data,
  input  logic [3:0]   wr_keep,
  input  logic         clear,
  output logic [127:0] blk_data,
  output logic [15:0]  blk_keep,
  output logic [4:0]   fill,
  output logic [4:0]   fill_next
);

  logic [4:0] fill_reg;

  assign fill      = fill_reg;
  assign fill_next = fill_reg + 5'(keep_bytes(wr_keep));

  // Fill offset: advances by the kept byte count, returns to 0 once the block leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fill_reg <= '0;
    else if (clear)  fill_reg <= '0;
    else if (wr_en)  fill_reg <= fill_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < BLK_BYTES; gi++) begin : g_byte
      logic [7:0] byte_reg;
      logic       keep_reg;
      logic [4:0] lane;
      logic       hit;

      assign lane = 5'(gi) - fill_reg;
      assign hit  = wr_en && (5'(gi) >= fill_reg) && (lane < 5'(WORD_BYTES)) &&
                    wr_keep[lane[1:0]];

      // Byte slot: captures its input lane when addressed, otherwise holds (zero after clear).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          byte_reg <= '0;
          keep_reg <= 1'b0;
        end else if (clear) begin
          byte_reg <= '0;
          keep_reg <= 1'b0;
        end else if (hit) begin
          byte_reg <= wr_data[{lane[1:0], 3'b000} +: 8];
          keep_reg <= 1'b1;
        end
      end

      assign blk_data[gi*8 +: 8] = byte_reg;
      assign blk_keep[gi]        = keep_reg;
    end
  endgenerate

endmodule

// File: rtl/poly1305_block_framer.sv
// Poly1305 block framer: packs an AAD segment and a payload segment of 32-bit
// words into 16-byte blocks, then emits the RFC 8439 length block.
// Optional input checking is enabled by defining POLY_FRAMER_ERR_EN.
module poly1305_block_framer
  import poly1305_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  poly1305_block_framer_if.slave        bus,
  output logic                          done,
  output logic                          err
);

  state_t       state_reg, state_next;
  logic         last_reg;
  logic [31:0]  aad_len, pld_len;
  logic         accept, bad, wr_en, clear, ends_block, zero_seg, phase_type;
  logic [127:0] blk_data;
  logic [15:0]  blk_keep;
  logic [4:0]   fill, fill_next;

  assign bus.in_ready = (state_reg == AAD_FILL) || (state_reg == PLD_FILL);
  assign accept       = bus.in_valid && bus.in_ready;
  assign phase_type   = (state_reg == PLD_FILL) ? TYPE_PLD : TYPE_AAD;

`ifdef POLY_FRAMER_ERR_EN
  assign bad = (bus.in_type != phase_type) ||
               (!(&bus.in_keep) && !bus.in_last) ||
               !keep_contig(bus.in_keep);
`else
  assign bad = 1'b0;
`endif

  // A malformed word is still consumed, it just never reaches the buffer.
  assign wr_en      = accept && !bad;
  assign ends_block = (fill_next == 5'(BLK_BYTES)) || (bus.in_last && (fill_next != 5'd0));
  assign zero_seg   = bus.in_last && (fill_next == 5'd0);
  assign clear      = ((state_reg == AAD_OUT) && bus.aad_ready) ||
                      ((state_reg == PLD_OUT) && bus.pld_ready);

  poly1305_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (bus.in_data),
    .wr_keep   (bus.in_keep),
    .clear     (clear),
    .blk_data  (blk_data),
    .blk_keep  (blk_keep),
    .fill      (fill),
    .fill_next (fill_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = AAD_FILL;
      AAD_FILL: if (wr_en) begin
                  if (ends_block)    state_next = AAD_OUT;
                  else if (zero_seg) state_next = PLD_FILL;
                end
      AAD_OUT:  if (bus.aad_ready) state_next = last_reg ? PLD_FILL : AAD_FILL;
      PLD_FILL: if (wr_en) begin
                  if (ends_block)    state_next = PLD_OUT;
                  else if (zero_seg) state_next = LEN_OUT;
                end
      PLD_OUT:  if (bus.pld_ready) state_next = last_reg ? LEN_OUT : PLD_FILL;
      LEN_OUT:  if (bus.len_ready) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Remember whether the block being emitted closes its segment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   last_reg <= 1'b0;
    else if (wr_en && ends_block) last_reg <= bus.in_last;
  end

  // Segment byte counters: cleared per frame, wrap modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aad_len <= '0;
      pld_len <= '0;
    end else if ((state_reg == IDLE) && start) begin
      aad_len <= '0;
      pld_len <= '0;
    end else if (wr_en) begin
      if (state_reg == AAD_FILL) aad_len <= aad_len + 32'(keep_bytes(bus.in_keep));
      else                       pld_len <= pld_len + 32'(keep_bytes(bus.in_keep));
    end
  end

`ifdef POLY_FRAMER_ERR_EN
  // Sticky error flag, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            err <= 1'b0;
    else if (accept && bad) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  assign bus.aad_valid = (state_reg == AAD_OUT);
  assign bus.aad_data  = bus.aad_valid ? blk_data : '0;
  assign bus.aad_keep  = bus.aad_valid ? blk_keep : '0;
  assign bus.pld_valid = (state_reg == PLD_OUT);
  assign bus.pld_data  = bus.pld_valid ? blk_data : '0;
  assign bus.pld_keep  = bus.pld_valid ? blk_keep : '0;
  assign bus.len_valid = (state_reg == LEN_OUT);
  assign bus.len_block = bus.len_valid ? {32'd0, pld_len, 32'd0, aad_len} : '0;
  assign done          = (state_reg == DONE);

endmodule

// File: tb/tb_poly1305_block_framer.sv
// Self-checking bench for poly1305_block_framer: random byte segments are
// framed and every emitted block, keep mask and length block is compared
// with blocks cut directly from the byte streams.
module tb_poly1305_block_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic done, err;

  poly1305_block_framer_if bus ();

  poly1305_block_framer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  // Segment byte streams and captured output blocks.
  logic [7:0]   aad_b[$];
  logic [7:0]   pld_b[$];
  logic [127:0] got_aad_d[$];
  logic [15:0]  got_aad_k[$];
  logic [127:0] got_pld_d[$];
  logic [15:0]  got_pld_k[$];
  logic [127:0] got_len[$];
  int           done_cnt = 0;

  // Back-pressure controls and monitor state.
  logic         hold_aad_req = 1'b0;
  logic         hold_pld_req = 1'b0;
  int           held_aad = 0;
  logic         mon_ar, mon_pr, mon_lr;
  logic         aad_wait = 1'b0, pld_wait = 1'b0;
  logic [127:0] aad_prev_d, pld_prev_d;
  logic [15:0]  aad_prev_k, pld_prev_k;

  // Consumer side: choose readies, check held outputs, capture transfers.
  always @(negedge clk) begin
    if (hold_aad_req && bus.aad_valid && held_aad < 5) begin
      mon_ar = 1'b0;
      held_aad++;
    end else begin
      mon_ar = ($urandom_range(0, 3) != 0);
    end
    mon_pr = hold_pld_req ? 1'b0 : ($urandom_range(0, 3) != 0);
    mon_lr = ($urandom_range(0, 2) != 0);
    if (!rst_n) begin
      aad_wait = 1'b0;
      pld_wait = 1'b0;
    end else begin
      if (aad_wait) begin
        chk("aad_hold_valid", 128'(bus.aad_valid), 128'd1);
        chk("aad_hold_data", bus.aad_data, aad_prev_d);
        chk("aad_hold_keep", 128'(bus.aad_keep), 128'(aad_prev_k));
      end
      if (pld_wait) begin
        chk("pld_hold_valid", 128'(bus.pld_valid), 128'd1);
        chk("pld_hold_data", bus.pld_data, pld_prev_d);
      end
      if (bus.aad_valid || bus.pld_valid || bus.len_valid)
        chk("in_ready_while_out", 128'(bus.in_ready), 128'd0);
      if (bus.aad_valid && mon_ar) begin
        got_aad_d.push_back(bus.aad_data);
        got_aad_k.push_back(bus.aad_keep);
        $display("aad block keep=%h data=%h", bus.aad_keep, bus.aad_data);
      end
      if (bus.pld_valid && mon_pr) begin
        got_pld_d.push_back(bus.pld_data);
        got_pld_k.push_back(bus.pld_keep);
        $display("pld block keep=%h data=%h", bus.pld_keep, bus.pld_data);
      end
      if (bus.len_valid && mon_lr) begin
        got_len.push_back(bus.len_block);
        $display("len block %h", bus.len_block);
      end
      if (done) done_cnt++;
      aad_wait   = bus.aad_valid && !mon_ar;
      aad_prev_d = bus.aad_data;
      aad_prev_k = bus.aad_keep;
      pld_wait   = bus.pld_valid && !mon_pr;
      pld_prev_d = bus.pld_data;
      pld_prev_k = bus.pld_keep;
    end
    bus.aad_ready = mon_ar;
    bus.pld_ready = mon_pr;
    bus.len_ready = mon_lr;
  end

  // Present one word and wait until it is transferred.
  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic t, input logic l);
    int w = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.in_type  = t;
    bus.in_last  = l;
    while (!bus.in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) timeout_fail("in_ready_wait");
    @(posedge clk);
  endtask

  // Cut a segment's byte stream into words; an empty segment is one keep=0 last word.
  task automatic send_seg(input bit is_pld);
    logic [7:0] q[$];
    logic [31:0] d;
    logic [3:0] k;
    int n;
    q = is_pld ? pld_b : aad_b;
    if (q.size() == 0) begin
      send_word(32'd0, 4'h0, is_pld, 1'b1);
    end else begin
      for (int i = 0; i < q.size(); i += 4) begin
        n = (q.size() - i < 4) ? q.size() - i : 4;
        d = '0;
        k = '0;
        for (int b = 0; b < n; b++) begin
          d[8*b +: 8] = q[i+b];
          k[b] = 1'b1;
        end
        send_word(d, k, is_pld, (i + 4 >= q.size()));
      end
    end
  endtask

  // Expected blocks: 16-byte slices of the stream, little-endian, zero padded.
  task automatic check_seg(input bit is_pld);
    logic [7:0]   q[$];
    logic [127:0] gd[$];
    logic [15:0]  gk[$];
    logic [127:0] ed;
    logic [15:0]  ek;
    int nblk;
    q  = is_pld ? pld_b : aad_b;
    gd = is_pld ? got_pld_d : got_aad_d;
    gk = is_pld ? got_pld_k : got_aad_k;
    nblk = (q.size() + 15) / 16;
    chk(is_pld ? "pld_block_count" : "aad_block_count", 128'(gd.size()), 128'(nblk));
    for (int j = 0; j < nblk && j < gd.size(); j++) begin
      ed = '0;
      ek = '0;
      for (int b = 0; b < 16; b++) begin
        if (16*j + b < q.size()) begin
          ed[8*b +: 8] = q[16*j + b];
          ek[b] = 1'b1;
        end
      end
      chk(is_pld ? "pld_data" : "aad_data", gd[j], ed);
      chk(is_pld ? "pld_keep" : "aad_keep", 128'(gk[j]), 128'(ek));
    end
  endtask

  task automatic make_bytes(input int la, input int lp, input bit seq);
    aad_b.delete();
    pld_b.delete();
    for (int i = 0; i < la; i++) aad_b.push_back(8'($urandom));
    for (int i = 0; i < lp; i++) pld_b.push_back(seq ? 8'(i) : 8'($urandom));
    got_aad_d.delete(); got_aad_k.delete();
    got_pld_d.delete(); got_pld_k.delete();
    got_len.delete();
    done_cnt = 0;
  endtask

  task automatic begin_frame();
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);   // extra high cycles land in AAD_FILL and must be ignored
    start = 1'b0;
  endtask

  task automatic run_frame(input int la, input int lp, input bit seq);
    int w = 0;
    logic [127:0] exp_len;
    make_bytes(la, lp, seq);
    begin_frame();
    send_seg(1'b0);
    send_seg(1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (done_cnt == 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (done_cnt == 0) timeout_fail("done_wait");
    repeat (3) @(negedge clk);
    check_seg(1'b0);
    check_seg(1'b1);
    exp_len = {64'(pld_b.size()), 64'(aad_b.size())};
    chk("len_count", 128'(got_len.size()), 128'd1);
    if (got_len.size() > 0) chk("len_block", got_len[0], exp_len);
    chk("done_pulses", 128'(done_cnt), 128'd1);
    chk("idle_in_ready", 128'(bus.in_ready), 128'd0);
    chk("err_clean", 128'(err), 128'd0);
    $display("frame aad=%0d pld=%0d finished", la, lp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'd0);
    chk({tag, "_aad_valid"}, 128'(bus.aad_valid), 128'd0);
    chk({tag, "_aad_data"}, bus.aad_data, 128'd0);
    chk({tag, "_pld_valid"}, 128'(bus.pld_valid), 128'd0);
    chk({tag, "_pld_data"}, bus.pld_data, 128'd0);
    chk({tag, "_pld_keep"}, 128'(bus.pld_keep), 128'd0);
    chk({tag, "_len_valid"}, 128'(bus.len_valid), 128'd0);
    chk({tag, "_len_block"}, bus.len_block, 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_err"}, 128'(err), 128'd0);
  endtask

  initial begin
    int w;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_keep  = '0;
    bus.in_type  = 1'b0;
    bus.in_last  = 1'b0;

    @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;

    run_frame(20, 0, 1'b0);            // two AAD blocks, second keep 000F
    run_frame(0, 16, 1'b1);            // empty AAD, payload bytes 00..0F
    hold_aad_req = 1'b1;
    run_frame(32, 5, 1'b0);            // first AAD block stalled 5 cycles
    hold_aad_req = 1'b0;
    chk("aad_stall_cycles", 128'(held_aad), 128'd5);
    run_frame(7, 10, 1'b0);            // payload last word keep 0011 -> keep 03FF

    // Reset while a payload block waits for pld_ready.
    hold_pld_req = 1'b1;
    make_bytes(0, 16, 1'b0);
    begin_frame();
    send_seg(1'b0);
    send_seg(1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.pld_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("pld_waiting", 128'(bus.pld_valid), 128'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    #2 rst_n = 1'b1;
    hold_pld_req = 1'b0;
    run_frame(9, 23, 1'b0);

    for (int f = 0; f < 6; f++)
      run_frame(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 1'b0);

`ifdef POLY_FRAMER_ERR_EN
    make_bytes(4, 0, 1'b0);
    begin_frame();
    send_word(32'h11223344, 4'hF, 1'b1, 1'b0);   // payload type while filling AAD
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("err_set", 128'(err), 128'd1);
    chk("err_word_dropped", 128'(bus.in_ready), 128'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 128'(err), 128'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("err_reset", 128'(err), 128'd0);
    #2 rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
